// File: rtl/sdes_key_scheduler.sv
// rtl/sdes_key_scheduler.sv - S-DES style subkey scheduler with ready/valid output stream
module sdes_key_scheduler #(
  parameter int NUM_ROUNDS = 2,
  parameter int ROUND_W    = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [9:0]         i_key,
  input  logic               i_decrypt,
  input  logic               i_key_valid,
  output logic               o_key_ready,
  input  logic               i_abort,
  output logic [7:0]         o_subkey,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_valid,
  output logic               o_last,
  input  logic               i_ready
);

  typedef enum logic {IDLE, GEN} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t     state, state_nxt;
  logic [9:0] p10_q;
  logic       dec_q;
  logic [3:0] rnd_q;
  logic       in_gen;
  logic       key_take;
  logic       step;
  logic       is_last;
  logic [2:0] shift;
  logic [4:0] left_rot, right_rot;
  logic [7:0] subkey;

  function automatic logic [9:0] perm10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  function automatic logic [7:0] perm8(input logic [9:0] v);
    return {v[4], v[7], v[3], v[6], v[2], v[5], v[0], v[1]};
  endfunction

  // Cumulative left rotation for round r is (2r - 1) mod 5.
  function automatic logic [2:0] round_shift(input logic [3:0] r);
    case (r)
      4'd1:    return 3'd1;
      4'd2:    return 3'd3;
      4'd3:    return 3'd0;
      4'd4:    return 3'd2;
      4'd5:    return 3'd4;
      4'd6:    return 3'd1;
      4'd7:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [4:0] rotl5(input logic [4:0] x, input logic [2:0] s);
    logic [9:0] d;
    d = {x, x} << s;
    return d[9:5];
  endfunction

  assign in_gen   = (state == GEN);
  assign key_take = (state == IDLE) && i_key_valid;
  assign step     = in_gen && i_ready && !i_abort;
  assign is_last  = dec_q ? (rnd_q == 4'd1) : (rnd_q == LAST_ROUND);

  assign shift     = round_shift(rnd_q);
  assign left_rot  = rotl5(p10_q[9:5], shift);
  assign right_rot = rotl5(p10_q[4:0], shift);
  assign subkey    = perm8({left_rot, right_rot});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_key_valid) state_nxt = GEN;
      GEN: begin
        if (i_abort)                 state_nxt = IDLE;
        else if (i_ready && is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_key_ready = (state == IDLE);
    o_valid     = in_gen;
    o_last      = in_gen && is_last;
    o_subkey    = in_gen ? subkey : 8'd0;
    o_round     = in_gen ? ROUND_W'(rnd_q) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p10_q <= 10'd0;
      dec_q <= 1'b0;
      rnd_q <= 4'd0;
    end else if (key_take) begin
      p10_q <= perm10(i_key);
      dec_q <= i_decrypt;
      rnd_q <= i_decrypt ? LAST_ROUND : 4'd1;
    end else if (step && !is_last) begin
      rnd_q <= dec_q ? rnd_q - 4'd1 : rnd_q + 4'd1;
    end
  end

endmodule
